// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: Avalon-MM slave UART transmitter with a byte FIFO.
//
// Frames are built from the byte at the FIFO head using a programmable baud
// divisor (each bit lasts DIV+1 clocks) and a runtime frame format: 5-8 data
// bits sent LSB first, optional even/odd parity, and 1 or 2 stop bits.
//
// Register map (avalon_address):
//   0 DATA   W : byteenable[0] pushes writedata[7:0]; reads 0
//   1 STATUS R : [FAW:0] level, [FAW+1] empty, [FAW+2] full, [FAW+3] busy
//   2 DIV    RW: [15:0] baud divisor, per-byte enables
//   3 CFG    RW: [1:0] data bits-5, [2] parity en, [3] odd, [4] two stop bits
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   avalon_read         read strobe (read data does not depend on it)
//   avalon_write        write strobe
//   avalon_address      register select
//   avalon_byteenable   byte enables
//   avalon_writedata    write data
//   avalon_readdata     read data, combinational from address
//   avalon_waitrequest  stall: only for a DATA write while the FIFO is full
//   uart_tx             registered serial output, idle high
module uart_tx_fifo #(
  parameter int          ADW     = 32,
  parameter int          ABW     = ADW / 8,
  parameter int          FAW     = 2,
  parameter logic [15:0] DIV_RST = 16'd433,
  parameter logic [4:0]  CFG_RST = 5'b00011
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           avalon_read,
  input  logic           avalon_write,
  input  logic [1:0]     avalon_address,
  input  logic [ABW-1:0] avalon_byteenable,
  input  logic [ADW-1:0] avalon_writedata,
  output logic [ADW-1:0] avalon_readdata,
  output logic           avalon_waitrequest,
  output logic           uart_tx
);

  localparam int DEPTH = 2 ** FAW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity over the low nsel+5 bits of d; odd inverts the even result.
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] nsel,
                                      input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, nsel});
    return (^(d & mask)) ^ odd;
  endfunction

  logic [7:0]     mem [DEPTH];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   level;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;

  logic [15:0]    div;
  logic [4:0]     cfg;

  logic [2:0]     state;
  logic [15:0]    cnt;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic [7:0]     shreg;
  logic [7:0]     data_f;
  logic [15:0]    div_f;
  logic [4:0]     cfg_f;
  logic           tx;
  logic           busy;
  logic           bit_done;
  logic           last_stop;
  logic [2:0]     last_idx;
  logic           unused_ok;

  assign empty     = (level == '0);
  assign full      = (level == (FAW + 1)'(DEPTH));
  assign busy      = (state != S_IDLE);
  assign bit_done  = (cnt == 16'd0);
  assign last_idx  = {1'b0, cfg_f[1:0]} + 3'd4;
  assign last_stop = (state == S_STOP) && bit_done && (!cfg_f[4] || stop_idx);

  // Full is the registered level, so a pop in the same cycle cannot release
  // a stalled write until the following cycle.
  assign push = avalon_write && (avalon_address == 2'd0) && avalon_byteenable[0] && !full;
  assign pop  = !empty && ((state == S_IDLE) || last_stop);

  assign avalon_waitrequest = avalon_write && (avalon_address == 2'd0) && full;
  assign uart_tx            = tx;

  assign unused_ok = &{1'b0, avalon_read, avalon_writedata, avalon_byteenable};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + (FAW + 1)'(1);
        2'b01:   level <= level - (FAW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avalon_writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= DIV_RST;
      cfg <= CFG_RST;
    end else if (avalon_write) begin
      if (avalon_address == 2'd2) begin
        if (avalon_byteenable[0]) div[7:0]  <= avalon_writedata[7:0];
        if (avalon_byteenable[1]) div[15:8] <= avalon_writedata[15:8];
      end
      if (avalon_address == 2'd3 && avalon_byteenable[0]) cfg <= avalon_writedata[4:0];
    end
  end

  // Shifter. A pop (from IDLE or at the end of the last stop bit) snapshots
  // the byte, DIV and CFG so register writes never disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (pop) begin
      shreg  <= mem[rd_ptr];
      data_f <= mem[rd_ptr];
      div_f  <= div;
      cfg_f  <= cfg;
      cnt    <= div;
      state  <= S_START;
      tx     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            cnt     <= div_f;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt <= div_f;
            if (bit_idx == last_idx) begin
              if (cfg_f[2]) begin
                state <= S_PARITY;
                tx    <= parity_bit(data_f, cfg_f[1:0], cfg_f[3]);
              end else begin
                state    <= S_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            cnt      <= div_f;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            if (last_stop) begin
              state <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= div_f;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    avalon_readdata = '0;
    case (avalon_address)
      2'd1: begin
        avalon_readdata[FAW:0] = level;
        avalon_readdata[FAW+1] = empty;
        avalon_readdata[FAW+2] = full;
        avalon_readdata[FAW+3] = busy;
      end
      2'd2:    avalon_readdata[15:0] = div;
      2'd3:    avalon_readdata[4:0]  = cfg;
      default: avalon_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avalon_read = 1'b0;
  logic        avalon_write = 1'b0;
  logic [1:0]  avalon_address = 2'd0;
  logic [3:0]  avalon_byteenable = 4'd0;
  logic [31:0] avalon_writedata = 32'd0;
  logic [31:0] avalon_readdata;
  logic        avalon_waitrequest;
  logic        uart_tx;

  int total = 0;
  int bad = 0;

  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk),
    .rst(rst),
    .avalon_read(avalon_read),
    .avalon_write(avalon_write),
    .avalon_address(avalon_address),
    .avalon_byteenable(avalon_byteenable),
    .avalon_writedata(avalon_writedata),
    .avalon_readdata(avalon_readdata),
    .avalon_waitrequest(avalon_waitrequest),
    .uart_tx(uart_tx)
  );

  typedef struct {
    string       name;
    logic        do_wr;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d,
                           output int stalls);
    stalls = 0;
    @(negedge clk);
    avalon_write = 1'b1;
    avalon_address = a;
    avalon_byteenable = be;
    avalon_writedata = d;
    #1;
    while (avalon_waitrequest === 1'b1 && stalls < 2000) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 2000) begin
      total++;
      bad++;
      $display("FAIL write_timeout: waitrequest still high after %0d cycles, required release", stalls);
    end
    @(posedge clk);
    #1;
    avalon_write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    int s;
    bus_write(a, be, d, s);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avalon_read = 1'b1;
    avalon_address = a;
    #1;
    d = avalon_readdata;
    #1;
    avalon_read = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(nm, d, exp);
  endtask

  // Reference: the line level for every clock of one frame.
  function automatic void add_frame(input logic [7:0] b, input int div, input logic [4:0] c);
    int   nb;
    int   ones;
    logic bits[$];
    nb = int'(c[1:0]) + 5;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (c[2]) bits.push_back(((ones % 2) == 1) ^ c[3]);
    bits.push_back(1'b1);
    if (c[4]) bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r <= div; r++) exp_q.push_back(bits[k]);
  endfunction

  // Wait for a start bit, then compare the line against exp_q cycle by cycle,
  // and require the line to be idle right after the last expected cycle.
  task automatic mon_frames(input string nm, output int waited);
    int   errs;
    int   first;
    logic fact;
    errs = 0;
    first = -1;
    fact = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (uart_tx !== 1'b0 && waited < 2000);
    if (uart_tx !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s_start: uart_tx=%b after %0d cycles, required 0", nm, uart_tx, waited);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (uart_tx !== exp_q[i]) begin
        if (errs == 0) begin
          first = i;
          fact = uart_tx;
        end
        errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_wave: %0d of %0d cycles wrong, first at cycle %0d got %b required %b",
               nm, errs, exp_q.size(), first, fact, exp_q[first]);
    end
    @(negedge clk);
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL %s_idle: uart_tx=%b after frames, required 1", nm, uart_tx);
    end
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] d;
    int n;
    n = 0;
    do begin
      rd(2'd1, d);
      n++;
    end while (d[5] === 1'b1 && n < 3000);
    check({nm, "_drained"}, d, 32'h08);
  endtask

  initial begin
    int waited;
    int stalls;
    logic [7:0] bytes[4];
    int nbytes;
    int rdiv;
    logic [4:0] rcfg;

    vecs[0]  = '{"rst_div",    1'b0, 2'd2, 4'h0, 32'h0,         32'h0000_01B1};
    vecs[1]  = '{"rst_cfg",    1'b0, 2'd3, 4'h0, 32'h0,         32'h0000_0003};
    vecs[2]  = '{"rst_status", 1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0008};
    vecs[3]  = '{"data_read",  1'b0, 2'd0, 4'h0, 32'h0,         32'h0000_0000};
    vecs[4]  = '{"div_be0",    1'b1, 2'd2, 4'h1, 32'hFFFF_12AB, 32'h0000_01AB};
    vecs[5]  = '{"div_be1",    1'b1, 2'd2, 4'h2, 32'h0000_3400, 32'h0000_34AB};
    vecs[6]  = '{"div_be_hi",  1'b1, 2'd2, 4'hC, 32'hFFFF_FFFF, 32'h0000_34AB};
    vecs[7]  = '{"div_full",   1'b1, 2'd2, 4'hF, 32'hDEAD_0005, 32'h0000_0005};
    vecs[8]  = '{"cfg_all",    1'b1, 2'd3, 4'h1, 32'hFFFF_FFFF, 32'h0000_001F};
    vecs[9]  = '{"cfg_no_be0", 1'b1, 2'd3, 4'h2, 32'h0000_0000, 32'h0000_001F};
    vecs[10] = '{"status_ro",  1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0008};
    vecs[11] = '{"cfg_8n1",    1'b1, 2'd3, 4'h1, 32'h0000_0003, 32'h0000_0003};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      rd_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // DIV=3, 8N1, 0x55: 40-cycle frame, start 2 cycles after the write edge.
    wr(2'd2, 4'h3, 32'd3);
    wr(2'd3, 4'h1, 32'h03);
    exp_q.delete();
    add_frame(8'h55, 3, 5'h03);
    wr(2'd0, 4'h1, 32'h55);
    mon_frames("a55", waited);
    check("a55_latency", waited, 32'd2);
    rd_check("a55_not_busy", 2'd1, 32'h08);

    // 7 bits, even parity, 2 stops, DIV=1, 0x07: 22 cycles; busy mid-frame.
    wr(2'd2, 4'h3, 32'd1);
    wr(2'd3, 4'h1, 32'h16);
    exp_q.delete();
    add_frame(8'h07, 1, 5'h16);
    fork
      begin
        wr(2'd0, 4'h1, 32'h07);
        repeat (4) @(negedge clk);
        rd_check("b07_busy", 2'd1, 32'h28);
      end
      mon_frames("b07", waited);
    join

    // Three queued bytes must go out with no idle gap.
    wr(2'd2, 4'h3, 32'd2);
    wr(2'd3, 4'h1, 32'h03);
    exp_q.delete();
    add_frame(8'hA5, 2, 5'h03);
    add_frame(8'h3C, 2, 5'h03);
    add_frame(8'hF0, 2, 5'h03);
    fork
      begin
        wr(2'd0, 4'h1, 32'hA5);
        wr(2'd0, 4'h1, 32'h3C);
        wr(2'd0, 4'h1, 32'hF0);
      end
      mon_frames("gapless", waited);
    join

    // Mid-frame DIV/CFG change applies only from the next frame.
    wr(2'd2, 4'h3, 32'd3);
    wr(2'd3, 4'h1, 32'h03);
    exp_q.delete();
    add_frame(8'h3C, 3, 5'h03);
    add_frame(8'hC3, 7, 5'h0F);
    fork
      begin
        wr(2'd0, 4'h1, 32'h3C);
        wr(2'd0, 4'h1, 32'hC3);
        repeat (10) @(negedge clk);
        wr(2'd2, 4'h3, 32'd7);
        wr(2'd3, 4'h1, 32'h0F);
      end
      mon_frames("midchg", waited);
    join

    // FIFO full: the write after the FIFO fills stalls until a pop frees space.
    wr(2'd2, 4'h3, 32'd9);
    wr(2'd3, 4'h1, 32'h03);
    for (int i = 0; i < 5; i++) wr(2'd0, 4'h1, 32'h10 + i);
    rd_check("full_status", 2'd1, 32'h34);
    bus_write(2'd0, 4'h1, 32'h99, stalls);
    total++;
    if (stalls < 80 || stalls > 110) begin
      bad++;
      $display("FAIL full_stall: stalled %0d cycles, required 80..110", stalls);
    end
    rd_check("refill_status", 2'd1, 32'h34);
    wait_idle("full");

    // Randomized frames against the reference model.
    for (int it = 0; it < 8; it++) begin
      rdiv = $urandom_range(0, 4);
      rcfg = 5'($urandom_range(0, 31));
      nbytes = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom_range(0, 255));
      wr(2'd2, 4'h3, 32'(rdiv));
      wr(2'd3, 4'h1, {27'd0, rcfg});
      exp_q.delete();
      for (int k = 0; k < nbytes; k++) add_frame(bytes[k], rdiv, rcfg);
      fork
        for (int k = 0; k < nbytes; k++) wr(2'd0, 4'h1, {24'd0, bytes[k]});
        mon_frames("rand", waited);
      join
      rd_check("rand_status", 2'd1, 32'h08);
    end

    // Reset in the DATA state with bytes queued.
    wr(2'd2, 4'h3, 32'd3);
    wr(2'd3, 4'h1, 32'h03);
    wr(2'd0, 4'h1, 32'h00);
    wr(2'd0, 4'h1, 32'h11);
    wr(2'd0, 4'h1, 32'h22);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
    rd_check("rst_mid_status", 2'd1, 32'h08);
    rd_check("rst_mid_div", 2'd2, 32'h0000_01B1);
    rd_check("rst_mid_cfg", 2'd3, 32'h0000_0003);
    repeat (20) @(negedge clk);
    check("rst_mid_quiet", {31'd0, uart_tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
